// File: rtl/issue_hazard_ctrl_pkg.sv
// Shared pipeline definitions for the dual-issue hazard/stall sequencer.
package issue_hazard_ctrl_pkg;

  typedef enum logic [0:0] {
    RUN      = 1'b0,
    DIV_WAIT = 1'b1
  } issue_state_t;

  // Total front-end stall cycles for one divide.
  localparam int unsigned DIV_CYCLES_DEFAULT = 32'd32;

  // Architectural zero register; never a real dependence.
  localparam logic [4:0] REG_ZERO = 5'd0;

endpackage

// File: rtl/issue_hazard_ctrl_load_use_detect.sv
// load_use_detect: combinational load-use check of one D-stage instruction
// against the master and slave loads currently in E.
module issue_hazard_ctrl_load_use_detect
  import issue_hazard_ctrl_pkg::*;
(
  input  logic [4:0] rs,
  input  logic [4:0] rt,
  input  logic       ren_rs,
  input  logic       ren_rt,
  input  logic       e_master_mem_ren,
  input  logic [4:0] e_master_waddr,
  input  logic       e_slave_mem_ren,
  input  logic [4:0] e_slave_waddr,
  output logic       hazard
);

  logic reads_rs_s;
  logic reads_rt_s;
  logic hit_master_s;
  logic hit_slave_s;

  // A load in E with a real destination matching an effective source read.
  always_comb begin
    reads_rs_s   = ren_rs && (rs != REG_ZERO);
    reads_rt_s   = ren_rt && (rt != REG_ZERO);
    hit_master_s = e_master_mem_ren && (e_master_waddr != REG_ZERO) &&
                   ((reads_rs_s && (rs == e_master_waddr)) ||
                    (reads_rt_s && (rt == e_master_waddr)));
    hit_slave_s  = e_slave_mem_ren && (e_slave_waddr != REG_ZERO) &&
                   ((reads_rs_s && (rs == e_slave_waddr)) ||
                    (reads_rt_s && (rt == e_slave_waddr)));
    hazard       = hit_master_s || hit_slave_s;
  end

endmodule

// File: rtl/issue_hazard_ctrl.sv
// issue_hazard_ctrl: dual-issue hazard and stall sequencer at the D/E
// boundary. Inserts one bubble on load-use hazards and freezes the front end
// for the full latency of a divide. Optional performance counters are built
// when ISSUE_HAZARD_PERF_EN is defined.
module issue_hazard_ctrl
  import issue_hazard_ctrl_pkg::*;
#(
  parameter int unsigned DIV_CYCLES = DIV_CYCLES_DEFAULT
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        flush,
  input  logic [4:0]  D_master_rs,
  input  logic [4:0]  D_master_rt,
  input  logic        D_master_ren_rs,
  input  logic        D_master_ren_rt,
  input  logic        D_master_reg_wen,
  input  logic [4:0]  D_master_reg_waddr,
  input  logic [4:0]  D_slave_rs,
  input  logic [4:0]  D_slave_rt,
  input  logic        D_slave_ren_rs,
  input  logic        D_slave_ren_rt,
  input  logic        D_slave_valid,
  input  logic        D_slave_solo,
  input  logic        E_master_mem_ren,
  input  logic        E_slave_mem_ren,
  input  logic [4:0]  E_master_reg_waddr,
  input  logic [4:0]  E_slave_reg_waddr,
  input  logic        E_div_start,
  output logic        D_stall,
  output logic        E_stall,
  output logic        E_bubble,
  output logic        D_slave_issue,
  output logic        div_busy
`ifdef ISSUE_HAZARD_PERF_EN
  ,
  output logic [31:0] perf_stall_cycles,
  output logic [31:0] perf_single_issue
`endif
);

  localparam int unsigned      CNT_W    = $clog2(DIV_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(DIV_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};

  issue_state_t     state_q, state_d;
  logic [CNT_W-1:0] div_cnt_q, div_cnt_d;

  logic master_lu_s;
  logic slave_lu_s;
  logic intra_dep_s;

  issue_hazard_ctrl_load_use_detect u_master_lu (
    .rs               (D_master_rs),
    .rt               (D_master_rt),
    .ren_rs           (D_master_ren_rs),
    .ren_rt           (D_master_ren_rt),
    .e_master_mem_ren (E_master_mem_ren),
    .e_master_waddr   (E_master_reg_waddr),
    .e_slave_mem_ren  (E_slave_mem_ren),
    .e_slave_waddr    (E_slave_reg_waddr),
    .hazard           (master_lu_s)
  );

  issue_hazard_ctrl_load_use_detect u_slave_lu (
    .rs               (D_slave_rs),
    .rt               (D_slave_rt),
    .ren_rs           (D_slave_ren_rs),
    .ren_rt           (D_slave_ren_rt),
    .e_master_mem_ren (E_master_mem_ren),
    .e_master_waddr   (E_master_reg_waddr),
    .e_slave_mem_ren  (E_slave_mem_ren),
    .e_slave_waddr    (E_slave_reg_waddr),
    .hazard           (slave_lu_s)
  );

  // Slave reads the register the master writes in the same pair.
  always_comb begin
    intra_dep_s = D_master_reg_wen && (D_master_reg_waddr != REG_ZERO) &&
                  ((D_slave_ren_rs && (D_slave_rs == D_master_reg_waddr)) ||
                   (D_slave_ren_rt && (D_slave_rt == D_master_reg_waddr)));
  end

  // Issue decision, stall outputs and next-state / divide counter update.
  always_comb begin
    state_d       = state_q;
    div_cnt_d     = div_cnt_q;
    D_stall       = 1'b0;
    E_stall       = 1'b0;
    E_bubble      = 1'b0;
    D_slave_issue = 1'b0;

    if (flush) begin
      E_bubble  = 1'b1;
      state_d   = RUN;
      div_cnt_d = CNT_ZERO;
    end else if ((state_q == DIV_WAIT) && (div_cnt_q != CNT_ZERO)) begin
      D_stall   = 1'b1;
      E_stall   = 1'b1;
      div_cnt_d = div_cnt_q - {{(CNT_W-1){1'b0}}, 1'b1};
    end else begin
      // RUN, or the final DIV_WAIT cycle which evaluates as RUN.
      state_d = RUN;
      if ((state_q == RUN) && E_div_start) begin
        D_stall   = 1'b1;
        E_stall   = 1'b1;
        div_cnt_d = CNT_LOAD;
        state_d   = DIV_WAIT;
      end else if (master_lu_s) begin
        D_stall  = 1'b1;
        E_bubble = 1'b1;
      end else begin
        D_slave_issue = D_slave_valid && !D_slave_solo &&
                        !intra_dep_s && !slave_lu_s;
      end
    end
  end

  // Busy flag is purely a view of the FSM state.
  always_comb begin
    div_busy = (state_q == DIV_WAIT);
  end

  // FSM state and divide countdown.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q   <= RUN;
      div_cnt_q <= CNT_ZERO;
    end else begin
      state_q   <= state_d;
      div_cnt_q <= div_cnt_d;
    end
  end

`ifdef ISSUE_HAZARD_PERF_EN
  logic [31:0] perf_stall_cycles_q, perf_stall_cycles_d;
  logic [31:0] perf_single_issue_q, perf_single_issue_d;

  // Wrap-around event counters; flush deliberately leaves them alone.
  always_comb begin
    if (D_stall) begin
      perf_stall_cycles_d = perf_stall_cycles_q + 32'd1;
    end else begin
      perf_stall_cycles_d = perf_stall_cycles_q;
    end
    if (D_slave_valid && !D_slave_issue) begin
      perf_single_issue_d = perf_single_issue_q + 32'd1;
    end else begin
      perf_single_issue_d = perf_single_issue_q;
    end
  end

  // Counter storage.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      perf_stall_cycles_q <= 32'd0;
      perf_single_issue_q <= 32'd0;
    end else begin
      perf_stall_cycles_q <= perf_stall_cycles_d;
      perf_single_issue_q <= perf_single_issue_d;
    end
  end

  assign perf_stall_cycles = perf_stall_cycles_q;
  assign perf_single_issue = perf_single_issue_q;
`endif

endmodule
